// File: rtl/ws2812_chain_tx_if.sv
// rtl/ws2812_chain_tx_if.sv - pixel word stream between pixel source and LED chain transmitter
interface ws2812_chain_tx_if #(
    parameter int BITS_PER_LED = 24
) ();
    logic [BITS_PER_LED-1:0] pix_data;
    logic                    pix_valid;
    logic                    pix_ready;

    // Pixel source side
    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    // Transmitter side
    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/ws2812_chain_tx.sv
// rtl/ws2812_chain_tx.sv - WS2812-class LED chain frame transmitter with NZR bit coding and latch period
module ws2812_chain_tx #(
    parameter int NUM_LEDS     = 8,
    parameter int BITS_PER_LED = 24,
    parameter int BIT_CYCLES   = 125,
    parameter int T0H_CYCLES   = 40,
    parameter int T1H_CYCLES   = 80,
    parameter int RESET_CYCLES = 28000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    ws2812_chain_tx_if.slave       pix,
    output logic                   dout,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   underrun
);

    // One counter serves both the bit period and the latch period.
    localparam int CMAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int CW   = (CMAX >= 2) ? $clog2(CMAX) : 1;
    localparam int BW   = (BITS_PER_LED >= 2) ? $clog2(BITS_PER_LED) : 1;
    localparam int LW   = (NUM_LEDS >= 2) ? $clog2(NUM_LEDS) : 1;
    localparam int AW   = $clog2(NUM_LEDS + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] T0H_C      = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H_C      = CW'(T1H_CYCLES);
    localparam logic [BW-1:0] BIT_IDX_LAST = BW'(BITS_PER_LED - 1);
    localparam logic [LW-1:0] LED_LAST   = LW'(NUM_LEDS - 1);
    localparam logic [AW-1:0] ACC_MAX    = AW'(NUM_LEDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_BITS  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [BITS_PER_LED-1:0] hold;
    logic                    hold_full;
    logic [BITS_PER_LED-1:0] shift;
    logic [CW-1:0]           cyc;
    logic [BW-1:0]           bit_cnt;
    logic [LW-1:0]           led_cnt;
    logic [AW-1:0]           acc;

    // Control strobes produced by the FSM and consumed by the datapath
    logic clear_frame;
    logic load_first;
    logic load_next;
    logic shift_bit;
    logic latch_underrun;
    logic latch_done;
    logic accept;

    logic bit_end;
    logic last_bit;
    logic last_led;

    assign bit_end  = (cyc == BIT_LAST);
    assign last_bit = (bit_cnt == BIT_IDX_LAST);
    assign last_led = (led_cnt == LED_LAST);
    assign accept   = pix.pix_valid && pix.pix_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, control strobes and outputs decoded from registered state
    always_comb begin
        state_nxt      = state;
        clear_frame    = 1'b0;
        load_first     = 1'b0;
        load_next      = 1'b0;
        shift_bit      = 1'b0;
        latch_underrun = 1'b0;
        latch_done     = 1'b0;
        dout           = 1'b0;
        busy           = 1'b1;
        pix.pix_ready  = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clear_frame = 1'b1;
                    state_nxt   = S_LOAD;
                end
            end

            S_LOAD: begin
                // The first pixel may take arbitrarily long; no underrun here.
                pix.pix_ready = !hold_full && (acc < ACC_MAX);
                if (hold_full) begin
                    load_first = 1'b1;
                    state_nxt  = S_BITS;
                end
            end

            S_BITS: begin
                pix.pix_ready = !hold_full && (acc < ACC_MAX);
                dout = (cyc < (shift[BITS_PER_LED-1] ? T1H_C : T0H_C));
                if (bit_end) begin
                    if (!last_bit) begin
                        shift_bit = 1'b1;
                    end else if (last_led) begin
                        state_nxt = S_LATCH;
                    end else if (hold_full) begin
                        load_next = 1'b1;
                    end else begin
                        // Next pixel missing at the boundary: abandon the rest.
                        latch_underrun = 1'b1;
                        state_nxt      = S_LATCH;
                    end
                end
            end

            S_LATCH: begin
                if (cyc == RST_LAST) begin
                    latch_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit/latch timing counter: wraps every bit in BITS, counts the latch in LATCH
    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc <= '0;
        end else begin
            case (state)
                S_BITS:  cyc <= bit_end ? '0 : cyc + 1'b1;
                S_LATCH: cyc <= (cyc == RST_LAST) ? '0 : cyc + 1'b1;
                default: cyc <= '0;
            endcase
        end
    end

    // Hold register, shift register and frame counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            led_cnt   <= '0;
            acc       <= '0;
        end else begin
            if (accept) begin
                hold      <= pix.pix_data;
                hold_full <= 1'b1;
                acc       <= acc + 1'b1;
            end

            // Loads only happen with hold_full set, while accept needs it clear,
            // so the two never collide on hold_full.
            if (load_first || load_next) begin
                shift     <= hold;
                hold_full <= 1'b0;
                bit_cnt   <= '0;
            end

            if (load_next) begin
                led_cnt <= led_cnt + 1'b1;
            end

            if (shift_bit) begin
                shift   <= shift << 1;
                bit_cnt <= bit_cnt + 1'b1;
            end

            // Any stale held word is dropped when the frame ends or restarts.
            if (clear_frame || latch_done) begin
                acc       <= '0;
                led_cnt   <= '0;
                hold_full <= 1'b0;
            end
        end
    end

    // Registered single-cycle status pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= latch_done;
            underrun   <= latch_underrun;
        end
    end

endmodule

// File: tb/tb_ws2812_chain_tx.sv
// tb/tb_ws2812_chain_tx.sv - directed self-checking bench for ws2812_chain_tx
module tb_ws2812_chain_tx;

    localparam int NL   = 2;
    localparam int BPL  = 24;
    localparam int BC   = 10;
    localparam int T0   = 3;
    localparam int T1   = 7;
    localparam int RC   = 20;
    localparam int NMAX = 600;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic dout;
    logic busy;
    logic frame_done;
    logic underrun;

    ws2812_chain_tx_if #(.BITS_PER_LED(BPL)) pix_if ();

    ws2812_chain_tx #(
        .NUM_LEDS    (NL),
        .BITS_PER_LED(BPL),
        .BIT_CYCLES  (BC),
        .T0H_CYCLES  (T0),
        .T1H_CYCLES  (T1),
        .RESET_CYCLES(RC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pix       (pix_if),
        .dout      (dout),
        .busy      (busy),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int ncap     = 0;

    logic tr_dout  [NMAX];
    logic tr_busy  [NMAX];
    logic tr_fd    [NMAX];
    logic tr_ur    [NMAX];
    logic tr_ready [NMAX];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start at edge E, then records outputs for cycles E..E+ncyc-1 while feeding words.
    task automatic run_frame(input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2,
                             input int nw, input int delay, input int gap, input int ncyc,
                             input int start_at, input int rst_at);
        logic [23:0] w [3];
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        ncap  = ncyc;
        n_acc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        fork
            begin
                for (int k = 0; k < ncyc; k++) begin
                    tr_dout[k]  = dout;
                    tr_busy[k]  = busy;
                    tr_fd[k]    = frame_done;
                    tr_ur[k]    = underrun;
                    tr_ready[k] = pix_if.pix_ready;
                    start = (k == start_at);
                    reset = (k == rst_at) ? 1'b0 : 1'b1;
                    step();
                end
                start = 1'b0;
                reset = 1'b1;
            end
            begin
                repeat (delay) step();
                for (int i = 0; i < nw; i++) begin
                    int t;
                    if (i == 1) repeat (gap) step();
                    pix_if.pix_data  = w[i];
                    pix_if.pix_valid = 1'b1;
                    t = 0;
                    while (!pix_if.pix_ready && t < 200) begin
                        step();
                        t++;
                    end
                    if (pix_if.pix_ready) begin
                        n_acc++;
                        step();
                    end
                    pix_if.pix_valid = 1'b0;
                end
            end
        join
    endtask

    // Compares the captured trace with the NZR waveform the pixel bits call for.
    task automatic analyze(input logic [47:0] bits, input int nbits, input int base,
                           input int exp_high, input int exp_done_k, input int exp_ur);
        int mism, highs, dones, done_k, urs, ur_k;
        mism = 0; highs = 0; dones = 0; done_k = -1; urs = 0; ur_k = -1;
        for (int k = 0; k < ncap; k++) begin
            logic e;
            int j;
            j = k - base;
            e = 1'b0;
            if (k >= base && j < nbits * BC) begin
                e = ((j % BC) < (bits[47 - (j / BC)] ? T1 : T0));
            end
            if (tr_dout[k] !== e) mism++;
            if (tr_dout[k] === 1'b1) highs++;
            if (tr_fd[k] === 1'b1) begin dones++; done_k = k; end
            if (tr_ur[k] === 1'b1) begin urs++; ur_k = k; end
        end
        check("dout_trace_mismatches", mism, 0);
        check("dout_high_cycles", highs, exp_high);
        check("frame_done_cycle", done_k, exp_done_k);
        check("frame_done_pulses", dones, 1);
        check("underrun_pulses", urs, exp_ur);
        if (exp_ur != 0) check("underrun_cycle", ur_k, base + nbits * BC);
        check("busy_in_done_cycle", int'(tr_busy[exp_done_k]), 0);
        check("busy_before_done", int'(tr_busy[exp_done_k - 1]), 1);
    endtask

    initial begin
        int cnt;
        reset = 1'b0;
        start = 1'b0;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data  = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            start            = 1'($urandom);
            pix_if.pix_valid = 1'($urandom);
            pix_if.pix_data  = 24'($urandom);
            step();
        end
        check("reset_dout", int'(dout), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pix_ready", int'(pix_if.pix_ready), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_underrun", int'(underrun), 0);
        start = 1'b0;
        pix_if.pix_valid = 1'b0;
        reset = 1'b1;
        step();
        step();

        // Full frame: 16 ones, 32 zeros -> 16*7 + 32*3 = 208 high cycles
        run_frame(24'hFF0000, 24'h00AA55, 24'h0, 2, 0, 0, 510, -1, -1);
        check("full_dout_E1", int'(tr_dout[1]), 0);
        check("full_dout_E2", int'(tr_dout[2]), 1);
        check("full_dout_E8", int'(tr_dout[8]), 1);
        check("full_dout_E9", int'(tr_dout[9]), 0);
        check("full_bit8_E84", int'(tr_dout[84]), 1);
        check("full_bit8_E85", int'(tr_dout[85]), 0);
        check("full_last_E478", int'(tr_dout[478]), 1);
        check("full_last_E479", int'(tr_dout[479]), 0);
        check("full_accepts", n_acc, 2);
        analyze({24'hFF0000, 24'h00AA55}, 48, 2, 208, 502, 0);
        step();

        // First pixel offered 50 cycles after start
        run_frame(24'hFF0000, 24'h00AA55, 24'h0, 2, 50, 0, 560, -1, -1);
        check("delay_dout_E51", int'(tr_dout[51]), 0);
        check("delay_dout_E52", int'(tr_dout[52]), 1);
        analyze({24'hFF0000, 24'h00AA55}, 48, 52, 208, 552, 0);
        step();

        // Underrun: 2 ones + 22 zeros -> 80 high cycles; second word offered late
        run_frame(24'h800001, 24'h123456, 24'h0, 2, 0, 250, 300, -1, -1);
        analyze({24'h800001, 24'h000000}, 24, 2, 80, 262, 1);
        check("underrun_accepts", n_acc, 1);
        cnt = 0;
        for (int k = 242; k < 300; k++) if (tr_ready[k] === 1'b1) cnt++;
        check("underrun_ready_after", cnt, 0);
        step();

        // Reset asserted in bit 10 of pixel 0 (cycles E+102..E+111)
        run_frame(24'hFF0000, 24'h00AA55, 24'h0, 2, 0, 0, 200, -1, 102);
        check("rst_mid_dout_before", int'(tr_dout[102]), 1);
        check("rst_mid_dout_after", int'(tr_dout[103]), 0);
        check("rst_mid_busy_after", int'(tr_busy[103]), 0);
        cnt = 0;
        for (int k = 0; k < 200; k++) if (tr_fd[k] === 1'b1) cnt++;
        check("rst_mid_no_done", cnt, 0);
        step();
        run_frame(24'hFF0000, 24'h00AA55, 24'h0, 2, 0, 0, 510, -1, -1);
        analyze({24'hFF0000, 24'h00AA55}, 48, 2, 208, 502, 0);
        step();

        // Start while busy and a third word offered
        run_frame(24'hFF0000, 24'h00AA55, 24'hFFFFFF, 3, 0, 0, 510, 100, -1);
        check("overrun_accepts", n_acc, 2);
        cnt = 0;
        for (int k = 10; k < 510; k++) if (tr_ready[k] === 1'b1) cnt++;
        check("overrun_ready_after", cnt, 0);
        analyze({24'hFF0000, 24'h00AA55}, 48, 2, 208, 502, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
